// File: rtl/cla_share_arb_pkg.sv
// Shared types and constants for the shared carry-lookahead adder arbiter.
package cla_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit carry-lookahead adder; carry out lands in o_result[WIDTH].
module carry_lookahead_adder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = i_add1 & i_add2;
    assign prop = i_add1 ^ i_add2;

    // Each carry is the flattened OR of generate terms propagated upward.
    always_comb begin
        logic term;
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & prop[m];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
    end

    assign o_result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter sharing one carry_lookahead_adder among NUM_REQ requesters.
// Define CLA_SHARE_ARB_STATS_EN to add per-requester saturating grant counters (o_grant_cnt).
module cla_share_arbiter
    import cla_share_arb_pkg::*;
#(
    parameter  int WIDTH   = 3,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_add1,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_add2,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_rsp_valid,
    output logic [WIDTH:0]             o_rsp_result,
    output logic [IDW-1:0]             o_rsp_id,
    input  logic                       i_rsp_ready,
`ifdef CLA_SHARE_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]  o_grant_cnt,
`endif
    output logic                       o_busy
);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] add1_q, add2_q;
    logic [WIDTH:0]   res_q;
    logic [WIDTH:0]   sum;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   next_ptr;
    logic             handshake;

    // First valid index at or after ptr, wrapping.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] win;
        logic           found;
        int             idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && vld[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        return win;
    endfunction

    assign grant_id  = rr_pick(i_req_valid, rr_ptr_q);
    assign next_ptr  = IDW'((int'(grant_id) + 1) % NUM_REQ);
    assign handshake = (state_q == IDLE) && (|i_req_valid);

    // Gated by i_rst so no grant is visible while reset is held.
    assign o_req_ready = (handshake && !i_rst) ? (NUM_REQ'(1) << grant_id) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            add1_q   <= '0;
            add2_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                add1_q   <= i_req_add1[grant_id*WIDTH +: WIDTH];
                add2_q   <= i_req_add2[grant_id*WIDTH +: WIDTH];
                id_q     <= grant_id;
                rr_ptr_q <= next_ptr;
            end
            if (state_q == CALC) res_q <= sum;
        end
    end

    carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
        .i_add1   (add1_q),
        .i_add2   (add2_q),
        .o_result (sum)
    );

    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_result = res_q;
    assign o_rsp_id     = id_q;
    assign o_busy       = (state_q != IDLE);

`ifdef CLA_SHARE_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] cnt_q;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                cnt_q[k] <= '0;
            end else if (handshake && (grant_id == IDW'(k)) && (cnt_q[k] != '1)) begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    assign o_grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed bench for cla_share_arbiter at WIDTH=3, NUM_REQ=4.
module tb_cla_share_arbiter;

    localparam int W   = 3;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_add1, req_add2;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [W:0]       rsp_result;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_ready;
    logic             busy;
`ifdef CLA_SHARE_ARB_STATS_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_add1   (req_add1),
        .i_req_add2   (req_add2),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_result (rsp_result),
        .o_rsp_id     (rsp_id),
        .i_rsp_ready  (rsp_ready),
`ifdef CLA_SHARE_ARB_STATS_EN
        .o_grant_cnt  (grant_cnt),
`endif
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_add1[k*W +: W] = a;
        req_add2[k*W +: W] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int e0;
        rst       = 1'b1;
        req_valid = 4'b0001;
        req_add1  = '0;
        req_add2  = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", rsp_result, 4'd0);
        chk("rst_id", rsp_id, 2'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single request, 3+4 on req0
        set_op(0, 3'd3, 3'd4);
        req_valid = 4'b0001;
        #1 chk("single_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("single_calc_valid", rsp_valid, 1'b0);
        chk("single_calc_busy", busy, 1'b1);
        chk("single_calc_ready", req_ready, 4'b0000);
        step();
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_result", rsp_result, 4'd7);
        chk("single_id", rsp_id, 2'd0);
        step();
        chk("single_done", rsp_valid, 1'b0);

        // Carry out, 7+7 on req2
        set_op(2, 3'd7, 3'd7);
        req_valid = 4'b0100;
        #1 chk("carry_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        chk("carry_result", rsp_result, 4'b1110);
        chk("carry_id", rsp_id, 2'd2);
        step();

        // Round robin from a fresh pointer
        do_reset();
        for (int k = 0; k < N; k++) set_op(k, W'(k), W'(k + 1));
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            int g;
            g = t % N;
            #1 chk($sformatf("rr_grant%0d", t), req_ready, 4'b0001 << g);
            step();
            step();
            chk($sformatf("rr_id%0d", t), rsp_id, g);
            chk($sformatf("rr_result%0d", t), rsp_result, 2 * g + 1);
            step();
        end
        req_valid = '0;

        // Backpressure; pointer now at 1, only req3 valid
        rsp_ready = 1'b0;
        set_op(3, 3'd4, 3'd5);
        req_valid = 4'b1000;
        #1 chk("bp_ready", req_ready, 4'b1000);
        step();
        req_valid = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid%0d", c), rsp_valid, 1'b1);
            chk($sformatf("bp_result%0d", c), rsp_result, 4'd9);
            chk($sformatf("bp_id%0d", c), rsp_id, 2'd3);
            chk($sformatf("bp_ready%0d", c), req_ready, 4'b0000);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", rsp_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);
        step();
        chk("bp_single_rsp", rsp_valid, 1'b0);

        // Reset while in RESP
        rsp_ready = 1'b0;
        set_op(1, 3'd2, 3'd3);
        req_valid = 4'b0010;
        #1;
        step();
        req_valid = '0;
        step();
        chk("mid_rsp_valid", rsp_valid, 1'b1);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_result", rsp_result, 4'd0);
        chk("mid_rst_id", rsp_id, 2'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", req_ready, 4'b0000);
        rst = 1'b0;
        #0.5;
        chk("post_rst_grant", req_ready, 4'b0010);
        @(negedge clk);
        step();
        req_valid = '0;
        chk("post_rst_result", rsp_result, 4'd5);
        chk("post_rst_id", rsp_id, 2'd1);
        step();

        // Exhaustive operand sweep on req1
        e0 = n_err;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                set_op(1, W'(a), W'(b));
                req_valid = 4'b0010;
                #1 chk($sformatf("ex_ready_%0d_%0d", a, b), req_ready, 4'b0010);
                step();
                req_valid = '0;
                step();
                chk($sformatf("ex_sum_%0d_%0d", a, b), rsp_result, a + b);
                chk($sformatf("ex_id_%0d_%0d", a, b), rsp_id, 2'd1);
                step();
            end
        end
        if (n_err == e0) $display("exhaustive sum check PASSED: 0 errors");
        else $display("FAIL exhaustive sum check FAILED: %0d errors, expected 0", n_err - e0);

`ifdef CLA_SHARE_ARB_STATS_EN
        do_reset();
        #1 chk("stats_reset", grant_cnt[15:0], 16'd0);
        set_op(0, 3'd1, 3'd1);
        req_valid = 4'b0001;
        repeat (70000 * 3 + 3) @(negedge clk);
        req_valid = '0;
        chk("stats_sat", grant_cnt[15:0], 16'hFFFF);
        chk("stats_other", grant_cnt[31:16], 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cla_share_arbiter.md
CLA_SHARE_ARBITER -- requirements
Module: cla_share_arbiter

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 3, operand width in bits.
REQ-002 The parameter list SHALL be: NUM_REQ, default 4, number of requesters (2..16); IDW = max(1, $clog2(NUM_REQ)).
REQ-003 The port list SHALL be:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; asynchronous and active-high.
- i_req_valid  in  NUM_REQ  per-requester request.
- i_req_add1  in  NUM_REQ*WIDTH  operand 1; requester k uses bits [k*WIDTH +: WIDTH].
- i_req_add2  in  NUM_REQ*WIDTH  operand 2; same packing as i_req_add1.
- o_req_ready  out  NUM_REQ  one-hot grant; handshake when valid & ready.
- o_rsp_valid  out  1  result available.
- o_rsp_result  out  WIDTH+1  sum, carry in the MSB.
- o_rsp_id  out  IDW  index of the requester that owns the result.
- i_rsp_ready  in  1  consumer accepts the result.
- o_busy  out  1  high in every state except IDLE.

Function
REQ-004 The block SHALL share one carry_lookahead_adder instance between NUM_REQ requesters using a three-state FSM: IDLE, CALC, RESP.
REQ-005 In IDLE with any i_req_valid high, the block SHALL assert exactly one o_req_ready bit combinationally, for the winner.
- The winner is the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-006 On that edge the block SHALL latch the winner's operands and index, set rr_ptr = (winner+1) mod NUM_REQ, and go to CALC.
REQ-007 In IDLE with no valid request, o_req_ready SHALL be all zero and the state SHALL be held.
REQ-008 In CALC the block SHALL register the adder output into the result register and go to RESP; CALC lasts exactly one cycle.
REQ-009 In RESP, o_rsp_valid SHALL be 1, and o_rsp_result/o_rsp_id SHALL be stable until i_rsp_ready is sampled high; the FSM then returns to IDLE.
REQ-010 Latency SHALL be: handshake at edge N gives o_rsp_valid at edge N+2. With i_rsp_ready tied high, the next grant occurs no earlier than edge N+3.
REQ-011 o_req_ready SHALL be all zero in CALC and RESP; requests arriving then wait.
REQ-012 Requesters SHALL hold valid and operands stable until granted; a requester that drops valid before its grant is simply not served.
REQ-013 The sum SHALL be the full unsigned WIDTH+1-bit result; 7+7 at WIDTH=3 gives 14 with the carry bit set.
REQ-014 i_rsp_ready outside RESP SHALL be ignored.

Reset
REQ-015 Asserting i_rst SHALL force, immediately and in any state (including mid-CALC or RESP): state=IDLE, rr_ptr=0, o_rsp_valid=0, o_rsp_result=0, o_rsp_id=0, o_busy=0, and o_req_ready=0 while i_rst is high.
REQ-016 An in-flight transaction aborted by reset SHALL be discarded, not replayed.
REQ-017 The first grant after reset release SHALL go to the lowest-indexed valid requester.

Configuration
REQ-018 With CLA_SHARE_ARB_STATS_EN defined, the block SHALL add output o_grant_cnt (NUM_REQ*16 bits).
- It holds one 16-bit saturating counter per requester, incremented on each handshake and held at 16'hFFFF.
- The counters reset to 0 asynchronously.
REQ-019 Without CLA_SHARE_ARB_STATS_EN, the port and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-020 Package cla_share_arb_pkg SHALL hold the FSM state enum (IDLE, CALC, RESP) and the 16-bit statistics counter width constant.
REQ-021 The adder SHALL be the existing carry_lookahead_adder, instantiated once with .WIDTH(WIDTH); the round-robin picker SHALL be a function, not a sub-module.

Verification
REQ-022 The bench SHALL cover these directed scenarios at WIDTH=3, NUM_REQ=4:
- Single request: req0 valid, 3+4, i_rsp_ready=1 -> o_req_ready=0001, o_rsp_valid two edges later, result=7, id=0.
- Carry out: req2 valid, 7+7 -> result=14 (4'b1110), id=2.
- Round-robin fairness: all four valid continuously -> grant order 0,1,2,3,0; each rsp id matches its grant.
- Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> result/id stable, o_req_ready=0 throughout, one response on release.
- Reset mid-RESP: i_rst pulse while o_rsp_valid=1 -> o_rsp_valid drops the same cycle with no clock edge; next grant goes to the lowest valid index.
- Exhaustive sum check: all 64 operand pairs through req1 -> zero mismatches against add1+add2; bench prints PASSED/FAILED with error count.
- With CLA_SHARE_ARB_STATS_EN: 70000 grants to req0 -> o_grant_cnt[15:0]=16'hFFFF.
